// File: rtl/chacha20_xor_sink.sv
// chacha20_xor_sink: keystream consumer for ChaCha20.
// Buffers up to DEPTH 512-bit keystream pads and XORs each incoming data word
// with the next unused keystream word. Encrypt and decrypt are the same
// operation. A pad is retired after its last word or at end of message, so
// keystream words are never reused.
module chacha20_xor_sink #(
  parameter int WORD_W   = 32,
  parameter int KS_WORDS = 16,
  parameter int DEPTH    = 2
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       clear,
  input  logic [WORD_W*KS_WORDS-1:0] ks_data,
  input  logic                       ks_valid,
  output logic                       ks_ready,
  input  logic [WORD_W-1:0]          in_data,
  input  logic                       in_last,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WORD_W-1:0]          out_data,
  output logic                       out_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                pads_used
);

  localparam int KS_W   = WORD_W * KS_WORDS;
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int WIDX_W = $clog2(KS_WORDS);

  // Circular pointer advance; explicit wrap keeps DEPTH=1 correct too.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(DEPTH - 1)) begin
      n = {PTR_W{1'b0}};
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  logic [KS_W-1:0]   buf_r [DEPTH];
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [CNT_W-1:0]  count_r;
  logic [WIDX_W-1:0] widx_r;
  logic [WORD_W-1:0] out_data_r;
  logic              out_last_r;
  logic              out_valid_r;
  logic [31:0]       pads_used_r;

  logic              ks_ready_s;
  logic              in_ready_s;
  logic              push_s;
  logic              xfer_s;
  logic              pop_s;
  logic              out_free_s;
  logic [KS_W-1:0]   head_s;
  logic [WORD_W-1:0] ks_word_s;

  // Handshake decode: ready signals never look at their own valid, and clear
  // blocks every push and transfer in its cycle.
  always_comb begin
    ks_ready_s = (count_r != CNT_W'(DEPTH)) && !clear;
    out_free_s = !out_valid_r || out_ready;
    in_ready_s = (count_r != CNT_W'(0)) && out_free_s && !clear;
    push_s     = ks_valid && ks_ready_s;
    xfer_s     = in_valid && in_ready_s;
    pop_s      = xfer_s && ((widx_r == WIDX_W'(KS_WORDS - 1)) || in_last);
  end

  // Select the current keystream word from the head pad.
  always_comb begin
    head_s    = buf_r[rd_ptr_r];
    ks_word_s = {WORD_W{1'b0}};
    for (int i = 0; i < KS_WORDS; i++) begin
      if (widx_r == WIDX_W'(i)) begin
        ks_word_s = head_s[WORD_W*i +: WORD_W];
      end else begin
        ks_word_s = ks_word_s;
      end
    end
  end

  // Pad storage: written only on an accepted push.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        buf_r[i] <= {KS_W{1'b0}};
      end
    end else if (push_s) begin
      buf_r[wr_ptr_r] <= ks_data;
    end
  end

  // Buffer pointers, occupancy and word index within the head pad.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      widx_r   <= {WIDX_W{1'b0}};
    end else if (clear) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      widx_r   <= {WIDX_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
        widx_r   <= {WIDX_W{1'b0}};
      end else if (xfer_s) begin
        widx_r <= widx_r + WIDX_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered output stage: load on transfer, drop valid once consumed.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_data_r  <= {WORD_W{1'b0}};
      out_last_r  <= 1'b0;
      out_valid_r <= 1'b0;
    end else if (clear) begin
      out_valid_r <= 1'b0;
    end else if (xfer_s) begin
      out_data_r  <= in_data ^ ks_word_s;
      out_last_r  <= in_last;
      out_valid_r <= 1'b1;
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  // Retired-pad counter; survives clear, wraps naturally.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pads_used_r <= 32'd0;
    end else if (pop_s) begin
      pads_used_r <= pads_used_r + 32'd1;
    end
  end

  assign ks_ready  = ks_ready_s;
  assign in_ready  = in_ready_s;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign out_valid = out_valid_r;
  assign pads_used = pads_used_r;

endmodule

// File: tb/tb_chacha20_xor_sink.sv
// Scoreboard bench for chacha20_xor_sink: directed stimulus pushes
// hand-computed expected words; a negedge monitor pops and compares.
module tb_chacha20_xor_sink;
  localparam int D = 2;

  logic         clock = 1'b0;
  logic         reset_n;
  logic         clear;
  logic [511:0] ks_data;
  logic         ks_valid;
  logic         ks_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_last;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  pads_used;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  chacha20_xor_sink #(.WORD_W(32), .KS_WORDS(16), .DEPTH(D)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear),
    .ks_data(ks_data), .ks_valid(ks_valid), .ks_ready(ks_ready),
    .in_data(in_data), .in_last(in_last), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
    .pads_used(pads_used)
  );

  always #5 clock = ~clock;

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  function automatic logic [511:0] make_pad(input logic [31:0] base);
    logic [511:0] p;
    for (int i = 0; i < 16; i++) p[32*i +: 32] = base + 32'(i);
    return p;
  endfunction

  task automatic push_pad(input logic [31:0] base);
    logic ok;
    ok = 1'b0;
    ks_data  = make_pad(base);
    ks_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (ks_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    chk1("push_accept", ok, 1'b1);
    @(posedge clock);
    #1;
    ks_valid = 1'b0;
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic [31:0] e, output int waits);
    logic ok;
    ok       = 1'b0;
    waits    = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clock);
      if (in_ready === 1'b1) begin
        sb.push_back('{data: e, last: l});
        ok = 1'b1;
        break;
      end
      waits++;
    end
    chk1("send_accept", ok, 1'b1);
    @(posedge clock);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor state: previous-cycle view and a small occupancy model.
  logic        p_xfer = 1'b0, p_clear = 1'b0, p_ov = 1'b0, p_or = 1'b0, p_last = 1'b0;
  logic [31:0] p_data = 32'd0;
  int          m_count = 0, m_widx = 0;
  logic [31:0] m_pads = 32'd0;

  // Monitor: protocol checks, scoreboard pop/compare, model update.
  always @(negedge clock) begin : mon
    logic exp_v, xf, ps, pp;
    exp_t e;
    if (!reset_n) begin
      sb.delete();
      p_xfer = 1'b0; p_clear = 1'b0; p_ov = 1'b0; p_or = 1'b0;
      m_count = 0; m_widx = 0; m_pads = 32'd0;
    end else begin
      exp_v = p_xfer ? 1'b1 : (p_clear ? 1'b0 : (p_ov && !p_or));
      chk1("out_valid", out_valid, exp_v);
      if (p_ov && !p_or && !p_clear && !p_xfer) begin
        chk32("hold_data", out_data, p_data);
        chk1("hold_last", out_last, p_last);
      end
      chk1("ks_ready", ks_ready, (m_count != D) && !clear);
      chk1("in_ready", in_ready, (m_count != 0) && (!out_valid || out_ready) && !clear);
      chk32("pads_used", pads_used, m_pads);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk32("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          e = sb.pop_front();
          chk32("out_data", out_data, e.data);
          chk1("out_last", out_last, e.last);
        end
      end
      if (clear) sb.delete();
      xf = in_valid && in_ready;
      ps = ks_valid && ks_ready;
      if (clear) begin
        m_count = 0;
        m_widx  = 0;
      end else begin
        pp = xf && (m_widx == 15 || in_last);
        m_count = m_count + (ps ? 1 : 0) - (pp ? 1 : 0);
        if (pp) begin
          m_widx = 0;
          m_pads = m_pads + 32'd1;
        end else if (xf) begin
          m_widx = m_widx + 1;
        end
      end
      p_xfer = xf; p_clear = clear; p_ov = out_valid; p_or = out_ready;
      p_data = out_data; p_last = out_last;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int gaps;
    logic [31:0] d;
    logic [31:0] e;
    logic [31:0] base;
    reset_n = 1'b0; clear = 1'b0; ks_data = '0; ks_valid = 1'b0;
    in_data = 32'd0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clock);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk32("rst_out_data", out_data, 32'd0);
    chk1("rst_out_last", out_last, 1'b0);
    chk32("rst_pads", pads_used, 32'd0);
    chk1("rst_ks_ready", ks_ready, 1'b1);
    chk1("rst_in_ready", in_ready, 1'b0);
    @(posedge clock); #2 reset_n = 1'b1;
    @(posedge clock); #1;

    // Basic XOR: one pad, 16 words, widx==15 retires the pad.
    push_pad(32'h1000_0000);
    gaps = 0;
    for (int i = 0; i < 16; i++) begin
      send(32'hFFFF_FFFF, 1'b0, 32'hEFFF_FFFF - 32'(i), w);
      if (i > 0) gaps += w;
    end
    chk32("basic_gaps", 32'(gaps), 32'd0);
    @(negedge clock);
    chk32("basic_pads", pads_used, 32'd1);
    chk1("basic_ks_ready", ks_ready, 1'b1);
    @(posedge clock); #1;

    // Back-to-back: three pads pushed while 48 words stream.
    gaps = 0;
    fork
      begin
        push_pad(32'h2000_0000);
        push_pad(32'h3000_0000);
        push_pad(32'h4000_0000);
      end
      begin
        for (int k = 0; k < 48; k++) begin
          base = 32'h1000_0000 * 32'(k / 16 + 2);
          d = 32'(k);
          e = d ^ (base + 32'(k % 16));
          send(d, 1'b0, e, w);
          if (k > 0) gaps += w;
        end
      end
    join
    chk32("b2b_gaps", 32'(gaps), 32'd0);

    // Early last on word 5, next words from the following pad.
    push_pad(32'h5000_0000);
    push_pad(32'h6000_0000);
    for (int k = 0; k < 8; k++) begin
      d = 32'hA5A5_0000 + 32'(k);
      e = (k < 5) ? (d ^ (32'h5000_0000 + 32'(k))) : (d ^ (32'h6000_0000 + 32'(k - 5)));
      send(d, 1'(k == 4), e, w);
      if (k == 4) begin
        @(negedge clock);
        chk32("early_pads", pads_used, 32'd5);
        @(posedge clock); #1;
      end
    end

    // Backpressure mid-pad (pad 0x6000_0000 at word 3).
    send(32'h0F0F_0F0F, 1'b0, 32'h0F0F_0F0F ^ 32'h6000_0003, w);
    out_ready = 1'b0;
    fork
      begin
        repeat (4) @(posedge clock);
        #1 out_ready = 1'b1;
      end
      send(32'h1234_5678, 1'b0, 32'h1234_5678 ^ 32'h6000_0004, w);
    join
    chk32("bp_waits", 32'(w), 32'd4);
    send(32'hCAFE_BABE, 1'b1, 32'hCAFE_BABE ^ 32'h6000_0005, w);

    // Empty buffer: word waits until a pad arrives, transfers next cycle.
    fork
      begin
        repeat (3) @(posedge clock);
        #1 push_pad(32'h7000_0000);
      end
      send(32'h0000_FFFF, 1'b1, 32'h0000_FFFF ^ 32'h7000_0000, w);
    join
    chk32("empty_waits", 32'(w), 32'd4);

    // Clear after 7 words with a second pad buffered.
    push_pad(32'h8000_0000);
    push_pad(32'h9000_0000);
    for (int k = 0; k < 7; k++) begin
      send(32'(k), 1'b0, 32'(k) ^ (32'h8000_0000 + 32'(k)), w);
    end
    clear = 1'b1;
    @(negedge clock);
    chk1("clr_ks_ready", ks_ready, 1'b0);
    chk1("clr_in_ready", in_ready, 1'b0);
    @(posedge clock); #1 clear = 1'b0;
    @(negedge clock);
    chk1("clr_out_valid", out_valid, 1'b0);
    chk1("clr_ks_ready_after", ks_ready, 1'b1);
    chk1("clr_in_ready_after", in_ready, 1'b0);
    chk32("clr_pads", pads_used, 32'd7);
    @(posedge clock); #1;
    push_pad(32'hA000_0000);
    send(32'h5555_AAAA, 1'b1, 32'h5555_AAAA ^ 32'hA000_0000, w);

    // Asynchronous reset mid-message.
    push_pad(32'hB000_0000);
    push_pad(32'hC000_0000);
    for (int k = 0; k < 7; k++) begin
      d = 32'hFFFF_0000 + 32'(k);
      send(d, 1'b0, d ^ (32'hB000_0000 + 32'(k)), w);
    end
    #1 reset_n = 1'b0;
    #1;
    chk1("arst_out_valid", out_valid, 1'b0);
    chk32("arst_out_data", out_data, 32'd0);
    chk1("arst_out_last", out_last, 1'b0);
    chk32("arst_pads", pads_used, 32'd0);
    chk1("arst_ks_ready", ks_ready, 1'b1);
    chk1("arst_in_ready", in_ready, 1'b0);
    @(posedge clock); #2 reset_n = 1'b1;
    @(posedge clock); #1;
    push_pad(32'hD000_0000);
    send(32'h0000_0001, 1'b1, 32'h0000_0001 ^ 32'hD000_0000, w);
    repeat (3) @(negedge clock);
    chk32("post_rst_pads", pads_used, 32'd1);
    chk32("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
